// File: rtl/div_share_arbiter_if.sv
// +----------------------------------------------------------------------------+
// | Module  : div_share_arbiter_if                                             |
// | Brief   : Requester, divider-core and result bundle for div_share_arbiter. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

interface div_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 16
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_dividend;
    logic [NUM_REQ*DW-1:0] req_divisor;
    logic [NUM_REQ-1:0]    gnt;
    logic [DW-1:0]         div_dividend;
    logic [DW-1:0]         div_divisor;
    logic                  div_nd;
    logic                  div_rfd;
    logic [DW-1:0]         div_quotient;
    logic [DW-1:0]         div_fractional;
    logic [NUM_REQ-1:0]    res_valid;
    logic [DW-1:0]         res_quotient;
    logic [DW-1:0]         res_fractional;
    logic                  res_dz;

    // master: the arbiter itself; slave: requesters plus divider core
    modport master (
        input  req, req_dividend, req_divisor,
        input  div_rfd, div_quotient, div_fractional,
        output gnt, div_dividend, div_divisor, div_nd,
        output res_valid, res_quotient, res_fractional, res_dz
    );

    modport slave (
        output req, req_dividend, req_divisor,
        output div_rfd, div_quotient, div_fractional,
        input  gnt, div_dividend, div_divisor, div_nd,
        input  res_valid, res_quotient, res_fractional, res_dz
    );
endinterface

`default_nettype wire

// File: rtl/div_share_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : div_share_arbiter                                                |
// | Brief   : Round-robin sharing of one pipelined divider core with a tag     |
// |           pipeline routing each result back to its issuer.                 |
// |           Optional macro DIV_ZERO_CHECK_EN adds divide-by-zero override.   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module div_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DW      = 16,
    parameter int LATENCY = 20
) (
    input wire logic         clk,
    input wire logic         rst,
    div_share_arbiter_if.master bus
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    function automatic logic [IDW-1:0] f_wrap(input logic [IDW-1:0] base, input int unsigned off);
        int unsigned w_sum;
        w_sum = (32'(base) + off) % NUM_REQ;
        return w_sum[IDW-1:0];
    endfunction

    logic [IDW-1:0]     r_ptr;
    logic               w_found;
    logic               w_fire;
    logic [IDW-1:0]     w_win;
    logic [NUM_REQ-1:0] w_gnt;
    logic [DW-1:0]      w_sel_dividend;
    logic [DW-1:0]      w_sel_divisor;

    logic               r_div_nd;
    logic [DW-1:0]      r_div_dividend;
    logic [DW-1:0]      r_div_divisor;
    logic [IDW-1:0]     r_issue_id;

    logic               r_tag_v  [LATENCY];
    logic [IDW-1:0]     r_tag_id [LATENCY];

    logic [NUM_REQ-1:0] w_res_onehot;
    logic [NUM_REQ-1:0] r_res_valid;
    logic [DW-1:0]      r_res_quotient;
    logic [DW-1:0]      r_res_fractional;

    // Search upward from the pointer; gnt is forced low while reset is held
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.req[f_wrap(r_ptr, k)]) begin
                w_found = 1'b1;
                w_win   = f_wrap(r_ptr, k);
            end
        end
        w_fire = w_found && bus.div_rfd && !rst;
        w_gnt  = '0;
        if (w_fire) begin
            w_gnt[w_win] = 1'b1;
        end
    end

    always_comb begin
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == IDW'(i)) begin
                w_sel_dividend = bus.req_dividend[i*DW +: DW];
                w_sel_divisor  = bus.req_divisor[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr          <= '0;
            r_div_nd       <= 1'b0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_issue_id     <= '0;
        end else begin
            r_div_nd <= w_fire;
            if (w_fire) begin
                r_ptr          <= f_wrap(w_win, 1);
                r_div_dividend <= w_sel_dividend;
                r_div_divisor  <= w_sel_divisor;
                r_issue_id     <= w_win;
            end
        end
    end

    // Stage LATENCY-1 lines up with the core output for the op strobed by div_nd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < LATENCY; j++) begin
                r_tag_v[j]  <= 1'b0;
                r_tag_id[j] <= '0;
            end
        end else begin
            r_tag_v[0]  <= r_div_nd;
            r_tag_id[0] <= r_issue_id;
            for (int j = 1; j < LATENCY; j++) begin
                r_tag_v[j]  <= r_tag_v[j-1];
                r_tag_id[j] <= r_tag_id[j-1];
            end
        end
    end

    always_comb begin
        w_res_onehot = '0;
        if (r_tag_v[LATENCY-1]) begin
            w_res_onehot[r_tag_id[LATENCY-1]] = 1'b1;
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic r_issue_dz;
    logic r_tag_dz [LATENCY];
    logic r_res_dz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_issue_dz <= 1'b0;
            for (int j = 0; j < LATENCY; j++) begin
                r_tag_dz[j] <= 1'b0;
            end
        end else begin
            if (w_fire) begin
                r_issue_dz <= (w_sel_divisor == '0);
            end
            r_tag_dz[0] <= r_issue_dz;
            for (int j = 1; j < LATENCY; j++) begin
                r_tag_dz[j] <= r_tag_dz[j-1];
            end
        end
    end

    // A zero divisor still occupies a core slot; its core output is discarded
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid      <= '0;
            r_res_quotient   <= '0;
            r_res_fractional <= '0;
            r_res_dz         <= 1'b0;
        end else begin
            r_res_valid <= w_res_onehot;
            r_res_dz    <= r_tag_v[LATENCY-1] && r_tag_dz[LATENCY-1];
            if (r_tag_v[LATENCY-1]) begin
                r_res_quotient   <= r_tag_dz[LATENCY-1] ? {DW{1'b1}} : bus.div_quotient;
                r_res_fractional <= r_tag_dz[LATENCY-1] ? '0 : bus.div_fractional;
            end
        end
    end

    assign bus.res_dz = r_res_dz;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid      <= '0;
            r_res_quotient   <= '0;
            r_res_fractional <= '0;
        end else begin
            r_res_valid <= w_res_onehot;
            if (r_tag_v[LATENCY-1]) begin
                r_res_quotient   <= bus.div_quotient;
                r_res_fractional <= bus.div_fractional;
            end
        end
    end

    assign bus.res_dz = 1'b0;
`endif

    assign bus.gnt            = w_gnt;
    assign bus.div_nd         = r_div_nd;
    assign bus.div_dividend   = r_div_dividend;
    assign bus.div_divisor    = r_div_divisor;
    assign bus.res_valid      = r_res_valid;
    assign bus.res_quotient   = r_res_quotient;
    assign bus.res_fractional = r_res_fractional;

endmodule

`default_nettype wire

// File: tb/tb_div_share_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module  : tb_div_share_arbiter                                             |
// | Brief   : Directed self-checking bench with a behavioural divider core.    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_div_share_arbiter;

    localparam int NUM_REQ = 2;
    localparam int DW      = 16;
    localparam int LATENCY = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    div_share_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW)) bus ();

    div_share_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .LATENCY(LATENCY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural core: fixed LATENCY pipeline, sentinel values on divide by zero
    function automatic logic [15:0] core_q(input logic [15:0] a, input logic [15:0] b);
        if (b == 16'h0) return 16'hDEAD;
        return a / b;
    endfunction

    function automatic logic [15:0] core_f(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] r;
        if (b == 16'h0) return 16'hBEEF;
        r = {a % b, 16'h0} / {16'h0, b};
        return r[15:0];
    endfunction

    logic [DW-1:0] cq [LATENCY];
    logic [DW-1:0] cf [LATENCY];

    always @(posedge clk) begin
        cq[0] <= core_q(bus.div_dividend, bus.div_divisor);
        cf[0] <= core_f(bus.div_dividend, bus.div_divisor);
        for (int j = 1; j < LATENCY; j++) begin
            cq[j] <= cq[j-1];
            cf[j] <= cf[j-1];
        end
    end

    assign bus.div_quotient   = cq[LATENCY-1];
    assign bus.div_fractional = cf[LATENCY-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        bus.req_dividend[i*DW +: DW] = 16'(a);
        bus.req_divisor[i*DW +: DW]  = 16'(b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req          = '0;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.div_rfd      = 1'b1;
        #2;
        check("rst_gnt",  32'(bus.gnt), 0);
        check("rst_nd",   32'(bus.div_nd), 0);
        check("rst_rv",   32'(bus.res_valid), 0);
        check("rst_dz",   32'(bus.res_dz), 0);
        check("rst_dvd",  32'(bus.div_dividend), 0);
        check("rst_q",    32'(bus.res_quotient), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // 1: single op 100/7 from requester 0
        bus.req = 2'b01;
        set_op(0, 100, 7);
        @(negedge clk);
        check("t1_gnt", 32'(bus.gnt), 1);
        step();
        bus.req = 2'b00;
        check("t1_nd",  32'(bus.div_nd), 1);
        check("t1_dvd", 32'(bus.div_dividend), 100);
        check("t1_dvs", 32'(bus.div_divisor), 7);
        repeat (20) step();
        check("t1_early", 32'(bus.res_valid), 0);
        step();
        check("t1_rv",   32'(bus.res_valid), 1);
        check("t1_q",    32'(bus.res_quotient), 14);
        check("t1_frac", 32'(bus.res_fractional), 32'h4924);
        check("t1_dz",   32'(bus.res_dz), 0);
        step();
        check("t1_rv_off", 32'(bus.res_valid), 0);
        check("t1_q_hold", 32'(bus.res_quotient), 14);

        // Reset returns the pointer (now 1) to 0
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();

        // 2: both requesting, strict alternation from requester 0
        bus.req = 2'b11;
        set_op(0, 200, 10);
        set_op(1, 50, 4);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("t2_gnt", 32'(bus.gnt), (c % 2 == 0) ? 1 : 2);
            step();
        end
        bus.req = 2'b00;
        repeat (17) step();
        check("t2_early", 32'(bus.res_valid), 0);
        for (int c = 0; c < 4; c++) begin
            step();
            check("t2_rv", 32'(bus.res_valid), (c % 2 == 0) ? 1 : 2);
            check("t2_q",  32'(bus.res_quotient), (c % 2 == 0) ? 20 : 12);
        end
        repeat (3) step();

        // 3: core stalled, pointer must stay at 0
        bus.div_rfd = 1'b0;
        bus.req     = 2'b11;
        set_op(0, 1000, 3);
        set_op(1, 7, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t3_stall_gnt", 32'(bus.gnt), 0);
            step();
            check("t3_stall_nd",  32'(bus.div_nd), 0);
            check("t3_stall_dvd", 32'(bus.div_dividend), 50);
        end
        bus.div_rfd = 1'b1;
        @(negedge clk);
        check("t3_gnt0", 32'(bus.gnt), 1);
        step();
        check("t3_dvd0", 32'(bus.div_dividend), 1000);
        check("t3_nd0",  32'(bus.div_nd), 1);
        @(negedge clk);
        check("t3_gnt1", 32'(bus.gnt), 2);
        step();
        bus.req = 2'b00;
        check("t3_dvd1", 32'(bus.div_dividend), 7);
        repeat (20) step();
        check("t3_rv0",   32'(bus.res_valid), 1);
        check("t3_q0",    32'(bus.res_quotient), 333);
        check("t3_frac0", 32'(bus.res_fractional), 32'h5555);
        step();
        check("t3_rv1",   32'(bus.res_valid), 2);
        check("t3_q1",    32'(bus.res_quotient), 3);
        check("t3_frac1", 32'(bus.res_fractional), 32'h8000);
        repeat (3) step();

        // 4: 30 back-to-back ops; op k returns q=k+1 at cycle k+22
        set_op(0, 3, 3);
        set_op(1, 6, 3);
        bus.req = 2'b11;
        for (int c = 0; c < 53; c++) begin
            if (c == 30) bus.req = 2'b00;
            @(negedge clk);
            if (c < 30) check("t4_gnt", 32'(bus.gnt), (c % 2 == 0) ? 1 : 2);
            if (c == 21 || c == 52) begin
                check("t4_idle", 32'(bus.res_valid), 0);
            end else if (c >= 22) begin
                check("t4_rv", 32'(bus.res_valid), ((c - 22) % 2 == 0) ? 1 : 2);
                check("t4_q",  32'(bus.res_quotient), c - 21);
            end
            step();
            if (c + 2 < 30) set_op(c % 2, 3 * (c + 3), 3);
        end

        // 5: divide by zero
        bus.req = 2'b01;
        set_op(0, 50, 0);
        @(negedge clk);
        check("t5_gnt", 32'(bus.gnt), 1);
        step();
        bus.req = 2'b00;
        repeat (21) step();
        check("t5_rv", 32'(bus.res_valid), 1);
`ifdef DIV_ZERO_CHECK_EN
        check("t5_dz",   32'(bus.res_dz), 1);
        check("t5_q",    32'(bus.res_quotient), 32'hFFFF);
        check("t5_frac", 32'(bus.res_fractional), 0);
`else
        check("t5_dz",   32'(bus.res_dz), 0);
        check("t5_q",    32'(bus.res_quotient), 32'hDEAD);
        check("t5_frac", 32'(bus.res_fractional), 32'hBEEF);
`endif
        step();
        check("t5_dz_off", 32'(bus.res_dz), 0);
        repeat (2) step();

        // 6: reset with five ops in flight (pointer is 1 here)
        bus.req = 2'b11;
        set_op(0, 9, 3);
        set_op(1, 8, 2);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("t6_gnt", 32'(bus.gnt), (c % 2 == 0) ? 2 : 1);
            step();
        end
        @(negedge clk);
        check("t6_pre_nd", 32'(bus.div_nd), 1);
        rst = 1'b1;
        #1;
        check("t6_rst_gnt", 32'(bus.gnt), 0);
        check("t6_rst_nd",  32'(bus.div_nd), 0);
        check("t6_rst_dvd", 32'(bus.div_dividend), 0);
        check("t6_rst_q",   32'(bus.res_quotient), 0);
        check("t6_rst_rv",  32'(bus.res_valid), 0);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            check("t6_no_rv", 32'(bus.res_valid), 0);
        end
        step();
        bus.req = 2'b01;
        @(negedge clk);
        check("t6_new_gnt", 32'(bus.gnt), 1);
        step();
        bus.req = 2'b00;
        repeat (20) step();
        check("t6_new_early", 32'(bus.res_valid), 0);
        step();
        check("t6_new_rv", 32'(bus.res_valid), 1);
        check("t6_new_q",  32'(bus.res_quotient), 3);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
